instr_mem_ctrl: RTL and testbench
=================================

Name: instr_mem_ctrl

Overview:
Parametrised, loadable instruction memory for the 8-bit CPU; it is the next generation of the fixed 256x9 ROM.
- Synchronous storage, 1-cycle registered fetch with a valid handshake.
- Hardware clear-to-NOP sequence after reset.
- Streaming program-load port that replaces hardcoded contents.
- Sits between the program counter / fetch stage and an external loader (UART or testbench).

Parameters:
INSTR_W, 9, instruction word width in bits
ADDR_W, 8, fetch/load address width
DEPTH, 256, number of words; must satisfy DEPTH <= 2**ADDR_W
NOP_WORD, 9'b000_000_000, fill value after reset and return value on out-of-range fetch

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
fetch_req  input  1  fetch request; accepted only when fetch_ready=1
fetch_addr  input  ADDR_W  fetch address (PC)
fetch_ready  output  1  high in IDLE only
instr  output  INSTR_W  registered fetched word
instr_valid  output  1  one-cycle pulse, one cycle after an accepted fetch
addr_err  output  1  one-cycle pulse on out-of-range fetch or load write
load_start  input  1  begin a load burst; accepted only in IDLE
load_base  input  ADDR_W  first write address of the burst
load_valid  input  1  load_data is valid this cycle (LOAD state only)
load_data  input  INSTR_W  word to write
load_last  input  1  qualifies the final word of the burst (with load_valid)
load_done  output  1  one-cycle pulse, one cycle after the last word is written
parity_err  output  1  see Optional Feature; constant 0 without it
par_inject  input  1  see Optional Feature; ignored without it

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=CLEAR, clr_ptr=0, wr_ptr=0.
  - instr=NOP_WORD; instr_valid, addr_err, load_done, parity_err, fetch_ready all 0.
- Reset asserted mid-LOAD or mid-CLEAR aborts the operation; the CLEAR sequence restarts after release.
- CLEAR:
  - Each cycle: mem[clr_ptr]<=NOP_WORD, clr_ptr++.
  - After writing DEPTH-1, go to IDLE (exactly DEPTH cycles).
  - fetch_ready=0; fetch_req and load_start ignored.
- IDLE:
  - fetch_ready=1.
  - fetch_req: next cycle instr<=mem[fetch_addr], instr_valid=1.
  - fetch_addr>=DEPTH: instr<=NOP_WORD, instr_valid=1, addr_err=1, all in the same cycle.
  - instr holds its value between fetches; back-to-back fetches give one result per cycle.
- LOAD entry:
  - load_start in IDLE: wr_ptr<=load_base, next state LOAD.
  - fetch_req and load_start in the same cycle: the fetch is served from pre-load contents, then LOAD is entered.
- LOAD:
  - fetch_ready=0; fetch_req ignored, no instr_valid.
  - load_valid with wr_ptr<DEPTH: mem[wr_ptr]<=load_data, wr_ptr++.
  - load_valid with wr_ptr>=DEPTH: write dropped, addr_err pulse, no wrap-around.
  - load_valid & load_last: final write, return to IDLE, load_done=1 next cycle.
  - load_last without load_valid is ignored; load_start in LOAD is ignored.
- Read-during-write cannot occur: fetches are blocked in LOAD and CLEAR.
- All outputs are registered except fetch_ready, which is decoded from state.

Optional Feature:
Macro IMEM_PARITY_EN.
- Defined:
  - Each word stores INSTR_W+1 bits; extra bit = even parity (XOR) of the data.
  - Parity is written in CLEAR and LOAD.
  - In LOAD with par_inject=1, the stored parity bit is inverted.
  - On every fetch the parity is checked; parity_err pulses alongside instr_valid on mismatch, and instr still returns the stored data.
  - Out-of-range fetch: parity_err=0.
- Not defined: storage is INSTR_W bits, parity_err tied to 0, par_inject unused.

Test Plan:
1. Release rst_n, hold fetch_req=1 -> fetch_ready=0 for exactly 256 cycles; first fetch of addr 5 -> instr=9'b000_000_000, instr_valid pulse one cycle later.
2. load_start, load_base=0, stream 9'b000_000_001, 9'b001_010_011, 9'b010_001_100 with load_last on the third -> load_done pulse; fetches of 0,1,2 back-to-back -> those three words on consecutive cycles.
3. load_base=254, stream 4 words (last on 4th) -> addresses 254,255 written, addr_err pulses on words 3 and 4, load_done still pulses; fetch 0 unchanged.
4. DEPTH=200: fetch_addr=210 -> instr=NOP_WORD, instr_valid=1, addr_err=1 same cycle.
5. Drop rst_n mid-load after 2 words -> outputs at reset values; after CLEAR, fetch of those addresses -> NOP_WORD.
6. IMEM_PARITY_EN: load 9'b111_011_000 with par_inject=1 at addr 7 -> fetch 7 gives instr=9'b111_011_000 with parity_err=1; neighbouring address parity_err=0.

Source files
------------

// File: rtl/instr_mem_ctrl.sv
// Loadable instruction memory: clears itself to NOP after reset, serves 1-cycle registered
// fetches and accepts streamed program loads. Define IMEM_PARITY_EN to store/check even parity.
module instr_mem_ctrl #(
    parameter int                 INSTR_W  = 9,
    parameter int                 ADDR_W   = 8,
    parameter int                 DEPTH    = 256,
    parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_req,
    input  logic [ADDR_W-1:0]  fetch_addr,
    output logic               fetch_ready,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic               addr_err,
    input  logic               load_start,
    input  logic [ADDR_W-1:0]  load_base,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               load_done,
    output logic               parity_err,
    input  logic               par_inject
);

    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

`ifdef IMEM_PARITY_EN
    localparam int MEM_W = INSTR_W + 1;
    localparam logic [MEM_W-1:0] NOP_ENC = {^NOP_WORD, NOP_WORD};
`else
    localparam int MEM_W = INSTR_W;
    localparam logic [MEM_W-1:0] NOP_ENC = NOP_WORD;
`endif

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic                instr_valid_q, instr_valid_d;
    logic                addr_err_q, addr_err_d;
    logic                load_done_q, load_done_d;
    logic                parity_err_q, parity_err_d;

    logic [MEM_W-1:0]    mem [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [MEM_W-1:0]    mem_wdata;
    logic [MEM_W-1:0]    rd_word;
    logic [MEM_W-1:0]    load_enc;
    logic                rd_par_bad;
    logic                fetch_in_range;
    logic                wr_in_range;

    // wr_ptr carries one extra bit so a burst running off the top never wraps to 0
    assign fetch_in_range = {1'b0, fetch_addr} < DEPTH_X;
    assign wr_in_range    = wr_ptr_q < DEPTH_X;
    assign rd_word        = mem[fetch_addr];

`ifdef IMEM_PARITY_EN
    assign load_enc   = {(^load_data) ^ par_inject, load_data};
    assign rd_par_bad = ^rd_word;
`else
    logic unused_par_inject;
    assign unused_par_inject = par_inject;
    assign load_enc   = load_data;
    assign rd_par_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR: if (clr_ptr_q == CLR_LAST) state_d = S_IDLE;
            S_IDLE:  if (load_start) state_d = S_LOAD;
            S_LOAD:  if (load_valid && load_last) state_d = S_IDLE;
            default: state_d = S_CLEAR;
        endcase
    end

    always_comb begin
        fetch_ready = (state_q == S_IDLE);
    end

    always_comb begin
        clr_ptr_d     = clr_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        addr_err_d    = 1'b0;
        load_done_d   = 1'b0;
        parity_err_d  = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = clr_ptr_q;
        mem_wdata     = NOP_ENC;
        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            end
            S_IDLE: begin
                if (fetch_req) begin
                    instr_valid_d = 1'b1;
                    if (fetch_in_range) begin
                        instr_d      = rd_word[INSTR_W-1:0];
                        parity_err_d = rd_par_bad;
                    end else begin
                        instr_d    = NOP_WORD;
                        addr_err_d = 1'b1;
                    end
                end
                if (load_start) wr_ptr_d = {1'b0, load_base};
            end
            S_LOAD: begin
                if (load_valid) begin
                    if (wr_in_range) begin
                        mem_we    = 1'b1;
                        mem_waddr = wr_ptr_q[ADDR_W-1:0];
                        mem_wdata = load_enc;
                        wr_ptr_d  = wr_ptr_q + (ADDR_W+1)'(1);
                    end else begin
                        addr_err_d = 1'b1;
                    end
                    load_done_d = load_last;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_ptr_q     <= '0;
            wr_ptr_q      <= '0;
            instr_q       <= NOP_WORD;
            instr_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
            load_done_q   <= 1'b0;
            parity_err_q  <= 1'b0;
        end else begin
            clr_ptr_q     <= clr_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            addr_err_q    <= addr_err_d;
            load_done_q   <= load_done_d;
            parity_err_q  <= parity_err_d;
        end
    end

    // Storage has no reset; the CLEAR sweep gives it defined contents instead
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign addr_err    = addr_err_q;
    assign load_done   = load_done_q;
    assign parity_err  = parity_err_q;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Randomized scoreboard bench for instr_mem_ctrl; a second small-DEPTH instance covers
// out-of-range fetch/load behaviour.
module tb_instr_mem_ctrl;

    localparam int DEPTH = 256;
    localparam logic [8:0] NOP = 9'b000_000_000;
`ifdef IMEM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       fetch_req = 1'b0, load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0, par_inject = 1'b0;
    logic [7:0] fetch_addr = '0, load_base = '0;
    logic [8:0] load_data = '0;
    logic       fetch_ready, instr_valid, addr_err, load_done, parity_err;
    logic [8:0] instr;

    logic       s_fetch_req = 1'b0, s_load_start = 1'b0, s_load_valid = 1'b0, s_load_last = 1'b0, s_par_inject = 1'b0;
    logic [7:0] s_fetch_addr = '0, s_load_base = '0;
    logic [8:0] s_load_data = '0;
    logic       s_fetch_ready, s_instr_valid, s_addr_err, s_load_done, s_parity_err;
    logic [8:0] s_instr;

    instr_mem_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .instr(instr), .instr_valid(instr_valid), .addr_err(addr_err),
        .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_done(load_done),
        .parity_err(parity_err), .par_inject(par_inject)
    );

    instr_mem_ctrl #(.DEPTH(200)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(s_fetch_req), .fetch_addr(s_fetch_addr), .fetch_ready(s_fetch_ready),
        .instr(s_instr), .instr_valid(s_instr_valid), .addr_err(s_addr_err),
        .load_start(s_load_start), .load_base(s_load_base), .load_valid(s_load_valid),
        .load_data(s_load_data), .load_last(s_load_last), .load_done(s_load_done),
        .parity_err(s_parity_err), .par_inject(s_par_inject)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain word array plus a "parity was corrupted" flag per address
    logic [8:0] m_mem [DEPTH];
    bit         m_bad [DEPTH];

    typedef struct {
        logic [8:0] instr;
        logic       aerr;
        logic       perr;
        int         cyc;
    } fexp_t;

    fexp_t      fq[$];
    int         ldq[$];
    int         leq[$];
    logic [8:0] ld_words[$];
    bit         ld_injs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every cycle, compare the DUT outputs against whatever the scoreboard expects now
    fexp_t      mon_e;
    bit         mon_fv, mon_le, mon_ld;
    logic [8:0] mon_last_instr = NOP;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_last_instr = NOP;
        end else begin
            mon_fv = 1'b0;
            mon_le = 1'b0;
            mon_ld = 1'b0;
            if (fq.size() > 0 && fq[0].cyc == cyc) begin
                mon_fv = 1'b1;
                mon_e  = fq.pop_front();
            end
            if (leq.size() > 0 && leq[0] == cyc) begin
                mon_le = 1'b1;
                void'(leq.pop_front());
            end
            if (ldq.size() > 0 && ldq[0] == cyc) begin
                mon_ld = 1'b1;
                void'(ldq.pop_front());
            end
            chk("instr_valid", 32'(instr_valid), 32'(mon_fv));
            if (mon_fv) begin
                chk("instr", 32'(instr), 32'(mon_e.instr));
                chk("parity_err", 32'(parity_err), 32'(mon_e.perr));
                mon_last_instr = mon_e.instr;
            end else begin
                chk("instr_hold", 32'(instr), 32'(mon_last_instr));
                chk("parity_err_quiet", 32'(parity_err), 32'(1'b0));
            end
            chk("addr_err", 32'(addr_err), 32'((mon_fv ? mon_e.aerr : 1'b0) | mon_le));
            chk("load_done", 32'(load_done), 32'(mon_ld));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = NOP;
            m_bad[i] = 1'b0;
        end
    endtask

    task automatic exp_fetch(input int addr);
        fexp_t e;
        if (addr < DEPTH) begin
            e.instr = m_mem[8'(addr)];
            e.aerr  = 1'b0;
            e.perr  = PAR_EN ? m_bad[8'(addr)] : 1'b0;
        end else begin
            e.instr = NOP;
            e.aerr  = 1'b1;
            e.perr  = 1'b0;
        end
        e.cyc = cyc + 1;
        fq.push_back(e);
    endtask

    task automatic fetch(input int addr);
        chk("fetch_ready_idle", 32'(fetch_ready), 32'(1'b1));
        fetch_req  = 1'b1;
        fetch_addr = 8'(addr);
        exp_fetch(addr);
        tick();
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!fetch_ready && n < 400) begin
            n++;
            tick();
        end
        chk(name, 32'(n), 32'(DEPTH));
    endtask

    // Streams ld_words/ld_injs from base with random gaps and ignored-input noise
    task automatic load_burst(input int base, input bit with_fetch, input int fetch_a);
        int ptr = base;
        int n   = ld_words.size();
        chk("fetch_ready_pre_load", 32'(fetch_ready), 32'(1'b1));
        load_start = 1'b1;
        load_base  = 8'(base);
        fetch_req  = with_fetch;
        fetch_addr = 8'(fetch_a);
        if (with_fetch) exp_fetch(fetch_a);
        tick();
        load_start = 1'b0;
        fetch_req  = 1'b0;
        chk("fetch_ready_in_load", 32'(fetch_ready), 32'(1'b0));
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                load_valid = 1'b0;
                load_last  = 1'($urandom_range(0, 1));
                load_start = 1'($urandom_range(0, 1));
                load_base  = 8'($urandom);
                fetch_req  = 1'($urandom_range(0, 1));
                fetch_addr = 8'($urandom);
                load_data  = 9'($urandom);
                tick();
            end
            load_valid = 1'b1;
            load_data  = ld_words[i];
            par_inject = ld_injs[i];
            load_last  = (i == n - 1);
            load_start = 1'($urandom_range(0, 1));
            load_base  = 8'($urandom);
            fetch_req  = 1'($urandom_range(0, 1));
            fetch_addr = 8'($urandom);
            if (ptr < DEPTH) begin
                m_mem[8'(ptr)] = ld_words[i];
                m_bad[8'(ptr)] = ld_injs[i];
                ptr++;
            end else begin
                leq.push_back(cyc + 1);
            end
            if (i == n - 1) ldq.push_back(cyc + 1);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_start = 1'b0;
        fetch_req  = 1'b0;
        par_inject = 1'b0;
        chk("fetch_ready_post_load", 32'(fetch_ready), 32'(1'b1));
    endtask

    task automatic rand_words(input int n);
        ld_words.delete();
        ld_injs.delete();
        for (int i = 0; i < n; i++) begin
            ld_words.push_back(9'($urandom));
            ld_injs.push_back(1'($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        fetch_req  = 1'b1;
        fetch_addr = 8'd5;
        repeat (3) tick();
        chk("reset_instr", 32'(instr), 32'(NOP));
        chk("reset_instr_valid", 32'(instr_valid), 32'(1'b0));
        chk("reset_addr_err", 32'(addr_err), 32'(1'b0));
        chk("reset_load_done", 32'(load_done), 32'(1'b0));
        chk("reset_parity_err", 32'(parity_err), 32'(1'b0));
        chk("reset_fetch_ready", 32'(fetch_ready), 32'(1'b0));

        // Test 1: CLEAR lasts DEPTH cycles while fetch_req is held; then fetch addr 5
        rst_n = 1'b1;
        wait_ready("clear_cycles");
        exp_fetch(5);
        tick();
        fetch_req = 1'b0;
        tick();

        // Test 2: three-word load then back-to-back fetches
        ld_words = '{9'b000_000_001, 9'b001_010_011, 9'b010_001_100};
        ld_injs  = '{1'b0, 1'b0, 1'b0};
        load_burst(0, 1'b0, 0);
        fetch(0);
        fetch(1);
        fetch(2);
        fetch_req = 1'b0;
        tick();

        // Test 3: burst running off the top of memory
        rand_words(4);
        load_burst(254, 1'b0, 0);
        fetch(0);
        fetch(254);
        fetch(255);
        fetch_req = 1'b0;
        tick();

        // Test 6: injected parity error at address 7, neighbours clean
        ld_words = '{9'b111_011_000};
        ld_injs  = '{1'b1};
        load_burst(7, 1'b0, 0);
        fetch(6);
        fetch(7);
        fetch(8);
        fetch_req = 1'b0;
        tick();

        // Fetch coinciding with load_start sees pre-load contents
        rand_words(2);
        load_burst(0, 1'b1, 0);
        fetch(0);
        fetch_req = 1'b0;
        tick();

        // Test 4: DEPTH=200 instance, out-of-range load and fetch
        chk("s_fetch_ready", 32'(s_fetch_ready), 32'(1'b1));
        s_load_start = 1'b1;
        s_load_base  = 8'd199;
        tick();
        s_load_start = 1'b0;
        s_load_valid = 1'b1;
        s_load_data  = 9'h155;
        tick();
        s_load_data  = 9'h0AA;
        s_load_last  = 1'b1;
        tick();
        s_load_valid = 1'b0;
        s_load_last  = 1'b0;
        chk("s_load_oob_addr_err", 32'(s_addr_err), 32'(1'b1));
        chk("s_load_done", 32'(s_load_done), 32'(1'b1));
        s_fetch_req  = 1'b1;
        s_fetch_addr = 8'd199;
        tick();
        chk("s_fetch199_instr", 32'(s_instr), 32'(9'h155));
        chk("s_fetch199_valid", 32'(s_instr_valid), 32'(1'b1));
        chk("s_fetch199_addr_err", 32'(s_addr_err), 32'(1'b0));
        s_fetch_addr = 8'd210;
        tick();
        chk("s_fetch210_instr", 32'(s_instr), 32'(NOP));
        chk("s_fetch210_valid", 32'(s_instr_valid), 32'(1'b1));
        chk("s_fetch210_addr_err", 32'(s_addr_err), 32'(1'b1));
        chk("s_fetch210_parity_err", 32'(s_parity_err), 32'(1'b0));
        s_fetch_req = 1'b0;
        tick();
        chk("s_idle_valid", 32'(s_instr_valid), 32'(1'b0));
        chk("s_idle_addr_err", 32'(s_addr_err), 32'(1'b0));

        // Randomized mix of fetch bursts, loads and idle noise
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    repeat ($urandom_range(1, 5)) fetch(int'($urandom_range(0, DEPTH - 1)));
                    fetch_req = 1'b0;
                    tick();
                end
                1: begin
                    rand_words(int'($urandom_range(1, 5)));
                    load_burst(($urandom_range(0, 1) == 1) ? int'($urandom_range(250, 255))
                                                           : int'($urandom_range(0, 255)),
                               1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
                end
                default: begin
                    repeat ($urandom_range(1, 3)) begin
                        load_valid = 1'($urandom_range(0, 1));
                        load_last  = 1'($urandom_range(0, 1));
                        load_data  = 9'($urandom);
                        tick();
                    end
                    load_valid = 1'b0;
                    load_last  = 1'b0;
                end
            endcase
        end

        // Sweep all addresses against the model
        for (int a = 0; a < DEPTH; a++) fetch(a);
        fetch_req = 1'b0;
        tick();

        // Test 5: reset in the middle of a load, then CLEAR restores NOPs
        ld_words = '{9'h1FF};
        ld_injs  = '{1'b0};
        load_burst(40, 1'b0, 0);
        fetch(40);
        fetch_req = 1'b0;
        tick();
        load_start = 1'b1;
        load_base  = 8'd20;
        tick();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data  = 9'h0F0;
        tick();
        load_data  = 9'h10F;
        tick();
        load_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_instr", 32'(instr), 32'(NOP));
        chk("abort_instr_valid", 32'(instr_valid), 32'(1'b0));
        chk("abort_addr_err", 32'(addr_err), 32'(1'b0));
        chk("abort_load_done", 32'(load_done), 32'(1'b0));
        chk("abort_fetch_ready", 32'(fetch_ready), 32'(1'b0));
        model_clear();
        tick();
        rst_n = 1'b1;
        wait_ready("clear_cycles_after_abort");
        fetch(20);
        fetch(21);
        fetch(40);
        fetch(7);
        fetch_req = 1'b0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
